// File: rtl/sysid_check_master_if.sv
// Avalon-MM read channel between the system-ID check master and the control slave.
interface sysid_check_master_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/sysid_check_master.sv
// Reads system ID (word 0) and build timestamp (word 1) over Avalon-MM and
// flags whether the loaded FPGA image matches the expected values.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'd102,
  parameter logic [31:0] EXPECTED_TS    = 32'd1526570516,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  sysid_check_master_if.master       avm,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                id_value,
  output logic [31:0]                ts_value,
  output logic                       id_ok,
  output logic                       ts_ok,
  output logic                       timeout
);

  localparam int unsigned CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    LAT     = 2'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ID, S_WAIT_ID, S_RD_TS, S_WAIT_TS, S_DONE
  } state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_stall_cnt;
  logic [1:0]      r_lat_cnt;
  logic            r_auto_pend;
  logic [31:0]     r_id_value, r_ts_value;
  logic            r_id_ok, r_ts_ok, r_timeout;

  logic w_read, w_addr, w_busy, w_done;
  logic w_start, w_accept, w_cap_id, w_cap_ts, w_abort, w_in_wait;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_read    = 1'b0;
    w_addr    = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_start   = 1'b0;
    w_accept  = 1'b0;
    w_cap_id  = 1'b0;
    w_cap_ts  = 1'b0;
    w_abort   = 1'b0;
    w_in_wait = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start || r_auto_pend) begin
          w_start = 1'b1;
          w_next  = S_RD_ID;
        end
      end
      S_RD_ID, S_RD_TS: begin
        w_read = 1'b1;
        w_busy = 1'b1;
        w_addr = (r_state == S_RD_TS);
        if (!avm.avm_waitrequest) begin
          w_accept = 1'b1;
          if (LAT == 2'd0) begin
            w_cap_id = (r_state == S_RD_ID);
            w_cap_ts = (r_state == S_RD_TS);
            w_next   = (r_state == S_RD_ID) ? S_RD_TS : S_DONE;
          end else begin
            w_next   = (r_state == S_RD_ID) ? S_WAIT_ID : S_WAIT_TS;
          end
        end else if (r_stall_cnt == TO_LAST) begin
          // The stall that reaches the limit is the last cycle read is driven
          w_abort = 1'b1;
          w_next  = S_DONE;
        end
      end
      S_WAIT_ID, S_WAIT_TS: begin
        w_busy    = 1'b1;
        w_in_wait = 1'b1;
        w_addr    = (r_state == S_WAIT_TS);
        if (r_lat_cnt == LAT) begin
          w_cap_id = (r_state == S_WAIT_ID);
          w_cap_ts = (r_state == S_WAIT_TS);
          w_next   = (r_state == S_WAIT_ID) ? S_RD_TS : S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_auto_pend <= AUTO_START;
      r_stall_cnt <= '0;
      r_lat_cnt   <= '0;
    end else begin
      if (r_state == S_IDLE) r_auto_pend <= 1'b0;
      if (w_start || w_cap_id)
        r_stall_cnt <= '0;
      else if (w_read && avm.avm_waitrequest && (r_stall_cnt != TO_MAX))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_accept)       r_lat_cnt <= 2'd1;
      else if (w_in_wait) r_lat_cnt <= r_lat_cnt + 2'd1;
    end
  end

  // Flags are evaluated at timestamp capture so they are valid with the done pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_id_value <= '0;
      r_ts_value <= '0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_start) begin
        r_id_ok   <= 1'b0;
        r_ts_ok   <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_cap_id) r_id_value <= avm.avm_readdata;
      if (w_cap_ts) begin
        r_ts_value <= avm.avm_readdata;
        r_id_ok    <= (r_id_value == EXPECTED_ID);
        r_ts_ok    <= (avm.avm_readdata == EXPECTED_TS);
      end
      if (w_abort) r_timeout <= 1'b1;
    end
  end

  assign avm.avm_read    = w_read;
  assign avm.avm_address = w_addr;
  assign busy            = w_busy;
  assign done            = w_done;
  assign id_value        = r_id_value;
  assign ts_value        = r_ts_value;
  assign id_ok           = r_id_ok;
  assign ts_ok           = r_ts_ok;
  assign timeout         = r_timeout;

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench: three masters (latency 0, short timeout, latency 2) against
// simple slave models with hand-computed expectations.
module tb_sysid_check_master;
  localparam logic [31:0] ID_GOOD = 32'd102;
  localparam logic [31:0] TS_GOOD = 32'd1526570516;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]  start_v = '0;
  logic [2:0]  wreq_v  = '0;
  logic [31:0] id_rsp [3];
  logic [31:0] ts_rsp [3];

  logic [2:0]  busy_v, done_v, idok_v, tsok_v, to_v, rd_v, ad_v;
  logic [31:0] idv [3];
  logic [31:0] tsv [3];

  int n_err = 0;
  int n_chk = 0;
  int fd, nd, nr, nr1;

  sysid_check_master_if ifc0 ();
  sysid_check_master_if ifc1 ();
  sysid_check_master_if ifc2 ();

  assign ifc0.avm_waitrequest = wreq_v[0];
  assign ifc0.avm_readdata    = ifc0.avm_address ? ts_rsp[0] : id_rsp[0];
  assign ifc1.avm_waitrequest = wreq_v[1];
  assign ifc1.avm_readdata    = ifc1.avm_address ? ts_rsp[1] : id_rsp[1];
  assign ifc2.avm_waitrequest = wreq_v[2];

  // Two-cycle-latency slave: garbage except when the delayed response is valid
  logic p1v, p1a, p2v, p2a;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p1v <= 1'b0; p1a <= 1'b0; p2v <= 1'b0; p2a <= 1'b0;
    end else begin
      p1v <= ifc2.avm_read & ~ifc2.avm_waitrequest;
      p1a <= ifc2.avm_address;
      p2v <= p1v;
      p2a <= p1a;
    end
  end
  assign ifc2.avm_readdata = p2v ? (p2a ? ts_rsp[2] : id_rsp[2]) : 32'hDEADBEEF;

  assign rd_v = {ifc2.avm_read, ifc1.avm_read, ifc0.avm_read};
  assign ad_v = {ifc2.avm_address, ifc1.avm_address, ifc0.avm_address};

  sysid_check_master #(.EXPECTED_ID(ID_GOOD), .EXPECTED_TS(TS_GOOD), .READ_LATENCY(0),
                       .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start_v[0]), .avm(ifc0.master),
    .busy(busy_v[0]), .done(done_v[0]), .id_value(idv[0]), .ts_value(tsv[0]),
    .id_ok(idok_v[0]), .ts_ok(tsok_v[0]), .timeout(to_v[0]));

  sysid_check_master #(.EXPECTED_ID(ID_GOOD), .EXPECTED_TS(TS_GOOD), .READ_LATENCY(0),
                       .TIMEOUT_CYCLES(4), .AUTO_START(1'b1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start_v[1]), .avm(ifc1.master),
    .busy(busy_v[1]), .done(done_v[1]), .id_value(idv[1]), .ts_value(tsv[1]),
    .id_ok(idok_v[1]), .ts_ok(tsok_v[1]), .timeout(to_v[1]));

  sysid_check_master #(.EXPECTED_ID(ID_GOOD), .EXPECTED_TS(TS_GOOD), .READ_LATENCY(2),
                       .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .start(start_v[2]), .avm(ifc2.master),
    .busy(busy_v[2]), .done(done_v[2]), .id_value(idv[2]), .ts_value(tsv[2]),
    .id_ok(idok_v[2]), .ts_ok(tsok_v[2]), .timeout(to_v[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Pulse start on master k at cycle 0, then observe cycles 1..ncyc.
  // waitrequest is held high for cycles lo..hi.
  task automatic go(input int k, input int ncyc, input int lo, input int hi,
                    output int first_done, output int ndone, output int nrd, output int nrd1);
    first_done = -1; ndone = 0; nrd = 0; nrd1 = 0;
    start_v[k] = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      start_v[k] = 1'b0;
      wreq_v[k]  = (c >= lo) && (c <= hi);
      if (done_v[k]) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
      if (rd_v[k]) begin
        nrd++;
        if (ad_v[k]) nrd1++;
      end
    end
    wreq_v[k] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      id_rsp[i] = ID_GOOD;
      ts_rsp[i] = TS_GOOD;
    end

    // Reset state and auto-started check on the zero-wait slave
    repeat (2) step();
    check("rst_ctl", 32'({rd_v[0], ad_v[0], busy_v[0], done_v[0], idok_v[0], tsok_v[0], to_v[0]}), 32'd0);
    check("rst_id", idv[0], 32'd0);
    check("rst_ts", tsv[0], 32'd0);
    reset_n = 1'b1;
    step();
    check("auto_c1_rd_ad_busy", 32'({rd_v[0], ad_v[0], busy_v[0]}), 32'b101);
    step();
    check("auto_c2_rd_ad_busy", 32'({rd_v[0], ad_v[0], busy_v[0]}), 32'b111);
    step();
    check("auto_c3_rd_busy_done_ok_to", 32'({rd_v[0], busy_v[0], done_v[0], idok_v[0], tsok_v[0], to_v[0]}), 32'b001110);
    check("auto_id_value", idv[0], ID_GOOD);
    check("auto_ts_value", tsv[0], TS_GOOD);
    step();
    check("auto_c4_done_low", 32'(done_v[0]), 32'd0);

    // Wrong ID
    id_rsp[0] = 32'd101;
    go(0, 8, 99, 0, fd, nd, nr, nr1);
    check("badid_done_cycle", 32'(fd), 32'd3);
    check("badid_done_count", 32'(nd), 32'd1);
    check("badid_id_value", idv[0], 32'd101);
    check("badid_ok_flags", 32'({idok_v[0], tsok_v[0]}), 32'b01);
    id_rsp[0] = ID_GOOD;

    // Five stall cycles on the timestamp read
    go(0, 12, 2, 6, fd, nd, nr, nr1);
    check("stall_done_cycle", 32'(fd), 32'd8);
    check("stall_done_count", 32'(nd), 32'd1);
    check("stall_read_cycles", 32'(nr), 32'd7);
    check("stall_addr1_cycles", 32'(nr1), 32'd6);
    check("stall_ok_flags", 32'({idok_v[0], tsok_v[0], to_v[0]}), 32'b110);
    check("stall_ts_value", tsv[0], TS_GOOD);

    // Stuck waitrequest with TIMEOUT_CYCLES=4, then a healthy re-run
    go(1, 10, 1, 1000, fd, nd, nr, nr1);
    check("to_done_cycle", 32'(fd), 32'd5);
    check("to_done_count", 32'(nd), 32'd1);
    check("to_read_cycles", 32'(nr), 32'd4);
    check("to_flags_to_idok_tsok_busy", 32'({to_v[1], idok_v[1], tsok_v[1], busy_v[1]}), 32'b1000);
    go(1, 6, 99, 0, fd, nd, nr, nr1);
    check("to_rerun_done_cycle", 32'(fd), 32'd3);
    check("to_rerun_flags", 32'({to_v[1], idok_v[1], tsok_v[1]}), 32'b011);

    // Read latency 2 with garbage between accept and valid data
    go(2, 10, 99, 0, fd, nd, nr, nr1);
    check("lat2_done_cycle", 32'(fd), 32'd7);
    check("lat2_done_count", 32'(nd), 32'd1);
    check("lat2_id_value", idv[2], ID_GOOD);
    check("lat2_ts_value", tsv[2], TS_GOOD);
    check("lat2_ok_flags", 32'({idok_v[2], tsok_v[2], to_v[2]}), 32'b110);

    // Reset while in WAIT_ID, auto re-run, start ignored while busy
    start_v[2] = 1'b1;
    step();
    start_v[2] = 1'b0;
    step();
    check("midrst_pre_rd_busy", 32'({rd_v[2], busy_v[2]}), 32'b01);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_ctl", 32'({rd_v[2], ad_v[2], busy_v[2], done_v[2], idok_v[2], tsok_v[2], to_v[2]}), 32'd0);
    check("midrst_id", idv[2], 32'd0);
    check("midrst_ts", tsv[2], 32'd0);
    step();
    reset_n = 1'b1;
    fd = -1; nd = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 2) start_v[2] = 1'b1;
      if (c == 3) start_v[2] = 1'b0;
      if (done_v[2]) begin
        nd++;
        if (fd < 0) fd = c;
      end
    end
    check("rerun_done_cycle", 32'(fd), 32'd7);
    check("rerun_done_count", 32'(nd), 32'd1);
    check("rerun_ok_flags", 32'({idok_v[2], tsok_v[2], to_v[2]}), 32'b110);
    check("rerun_idle_busy", 32'(busy_v[2]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sysid_check_master.md
Name: sysid_check_master

Overview:
- Avalon-MM read master for the other end of the system-ID control slave: reads word 0 (system ID) and word 1 (build timestamp), then compares both against expected values.
- Sits beside the quadrature-decoder test logic. It gates decoder bring-up and drives status LEDs, so that a mismatched FPGA image is flagged before decoder tests run.
- Tolerates waitrequest stalls and a fixed read latency, so it also works behind an interconnect.

Parameters:
- EXPECTED_ID, 102, value required at word address 0
- EXPECTED_TS, 1526570516, value required at word address 1
- READ_LATENCY, 0, cycles from accepted read to valid readdata; legal 0..3; 0 means sample in the accept cycle
- TIMEOUT_CYCLES, 255, maximum cycles one read may stall on waitrequest before abort; must be >= 1
- AUTO_START, 1, 1 = start one check automatically on the first cycle after reset deassertion

Ports:
- clock  in  1  system clock; all state rising-edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run a check; ignored while busy=1
- avm_address  out  1  word address: 0 = ID, 1 = timestamp
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall; tie 0 for a zero-wait slave
- avm_readdata  in  32  read data
- busy  out  1  check in progress
- done  out  1  single-cycle pulse when a check completes or aborts
- id_value  out  32  last captured ID
- ts_value  out  32  last captured timestamp
- id_ok  out  1  id_value == EXPECTED_ID; sticky until next start
- ts_ok  out  1  ts_value == EXPECTED_TS; sticky until next start
- timeout  out  1  last check aborted on a stall; sticky until next start

Behaviour:
- Reset (async assert, sync deassert into logic): state IDLE; all outputs 0, including avm_address, avm_read, busy, done, id_value, ts_value, id_ok, ts_ok, timeout.
- Start condition: start=1 in IDLE, or AUTO_START=1 on the first cycle after reset. AUTO_START fires exactly once per reset.
- On the start condition, in one cycle:
  - clear id_ok, ts_ok, timeout
  - busy=1
  - go to RD_ID
- RD_ID: avm_read=1, avm_address=0, both held stable until accepted.
  - Accept = avm_read & !avm_waitrequest.
  - On accept, avm_read drops the next cycle.
  - READ_LATENCY=0: capture avm_readdata into id_value in the accept cycle, then go to RD_TS.
  - READ_LATENCY>0: go to WAIT_ID.
- WAIT_ID: count READ_LATENCY cycles after accept, capture on the cycle the count reaches READ_LATENCY, then go to RD_TS. avm_read=0 throughout.
- RD_TS / WAIT_TS: identical to RD_ID / WAIT_ID with avm_address=1, capturing into ts_value.
  - After the capture, go to DONE.
  - Minimum back-to-back case (latency 0, no stall): read asserted for exactly one cycle per word, no idle gap between the two reads.
- DONE, one cycle:
  - id_ok = (id_value == EXPECTED_ID); ts_ok = (ts_value == EXPECTED_TS)
  - done=1, busy=0 at the DONE register output
  - return to IDLE
  - Total no-stall latency from start to done = 2*(READ_LATENCY+1)+1 cycles.
- Timeout:
  - A stall counter resets on entry to each RD_* state and increments on every cycle with avm_read & avm_waitrequest.
  - When it reaches TIMEOUT_CYCLES: deassert avm_read, set timeout=1, leave id_ok=ts_ok=0, go to DONE. DONE skips the compare in this case; a word that was not captured keeps its previous value.
  - The counter saturates; it never wraps.
- start while busy: ignored, not queued.
- start in the same cycle as DONE: ignored; a new start is accepted only in IDLE.
- Comparisons are full 32-bit unsigned equality, with no masking.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. Any in-flight read response is discarded because the master does not count it.

Test Plan:
- Zero-wait slave returning 102 for address 0 and 1526570516 for address 1, READ_LATENCY=0, AUTO_START=1 -> read asserted at cycles 1 and 2 after reset with addresses 0 then 1, done pulse at cycle 3, id_ok=1, ts_ok=1, timeout=0.
- Slave returns 101 for address 0 -> id_value=101, id_ok=0, ts_ok=1, single done pulse.
- waitrequest held high for 5 cycles on the address-1 read -> avm_read and avm_address=1 stable across all 6 cycles, exactly one capture, done at cycle 8 after start, both ok flags set.
- waitrequest stuck high, TIMEOUT_CYCLES=4 -> avm_read deasserts after 4 stalled cycles, timeout=1, id_ok=ts_ok=0, done pulse, busy=0; a following start with a healthy slave clears timeout and passes.
- READ_LATENCY=2, with readdata valid 2 cycles after accept and garbage 0xDEADBEEF in the intervening cycles -> the correct values are captured and done arrives 7 cycles after start.
- reset_n pulsed low while in WAIT_ID -> all outputs 0 asynchronously; AUTO_START re-runs the check once after release and passes; a start pulse while busy produces no second done.
